dijkstra_frontier_ci: RTL and testbench
=======================================

# dijkstra_frontier_ci

Multi-cycle Nios II custom-instruction stage that holds the Dijkstra working set: per-node tentative distance, predecessor and visited flag. It sits directly upstream of the `direct_dijkstra` arithmetic custom instruction. Software relaxes edges through this block and pops the next frontier node with a hardware minimum scan. It uses the standard multi-cycle custom-instruction handshake: `start`, `done` and the `n` opcode select.

## Interface
- `NODES`, 64: number of table entries; a power of two, from 2 to 256.
- `DIST_W`, 32: distance width. The all-ones value means infinity.
- `clk` in 1: sole clock.
- `reset` in 1: asynchronous, active-low reset.
- `clk_en` in 1: clock enable; when low, all state freezes.
- `start` in 1: one-cycle request pulse.
- `n` in 3: opcode.
- `dataa` in 32: bits [15:0] are the node index; bits [31:16] are the predecessor for RELAX.
- `datab` in 32: distance operand, using bits [DIST_W-1:0].
- `done` out 1: one-cycle pulse; `result` is valid in that cycle.
- `result` out 32: operation result. It holds its value until the next `done`.

## Operation
- **Storage:** `dist[NODES]` (DIST_W bits each), `pred[NODES]` (16 bits each), `visited[NODES]` (1 bit each).
- **States:** IDLE, RELAX, READ, SCAN, COMMIT.
  - From IDLE, `start` with `clk_en` high decodes `n`.
  - `start` is ignored outside IDLE.
- **Opcodes:**
  - **n=0 CLEAR:** all `dist` set to infinity; all `pred` and `visited` set to 0. `result`=0.
  - **n=1 RELAX:**
    - Update condition: idx < NODES, `!visited[idx]`, and `datab` < `dist[idx]` (unsigned).
    - If the condition holds: `dist[idx]`←`datab`, `pred[idx]`←`dataa[31:16]`, `result`=1.
    - Otherwise: no write, `result`=0.
    - Equal distance does not update.
  - **n=2 EXTRACT_MIN:**
    - SCAN visits indices 0..NODES-1, one per cycle.
    - It tracks the minimum over entries with `!visited` and `dist` ≠ infinity.
    - The comparison is strict less-than, so a tie resolves to the lowest index.
    - COMMIT sets `visited[min]` and returns `result`=min, zero-extended.
    - If no candidate exists, `result`=0xFFFFFFFF and no flag changes.
  - **n=3 READ_DIST:** `result`=`dist[idx]`, zero-extended. An out-of-range idx returns 0xFFFFFFFF.
  - **n=4 READ_PRED:** `result`={16'b0, `pred[idx]`}. An out-of-range idx returns 0.
  - **n=5 SET_DIST:**
    - Writes `dist[idx]`←`datab` and clears `visited[idx]`; `result`=0.
    - An out-of-range idx is ignored.
    - This opcode is used to seed the source node.
  - **n=6,7:** no operation; `result`=0.
- **Index rules:** the index is `dataa[15:0]`; bits above log2(NODES) make the index out of range. `dataa` and `datab` are latched at `start`.

## Timing
- Let `start` be sampled at edge T, with `clk_en` high throughout. `done` is high in the cycle after:
  - CLEAR, SET_DIST, n=6,7: edge T+1.
  - RELAX, READ_DIST, READ_PRED: edge T+2 (read, then compare/write).
  - EXTRACT_MIN: edge T+NODES+1 (NODES scan edges, then COMMIT).
- **Write timing:** table writes take effect on the same edge that raises `done`. A back-to-back `start` in the `done` cycle is ignored; the next `start` is accepted from the following cycle.
- **Clock enable:** `clk_en` low stretches every state and holds `done` low. A pending `done` is emitted once `clk_en` returns.
- **Reset** (asynchronous assert, synchronous deassert expected upstream):
  - `done`=0, `result`=0, state=IDLE.
  - All `dist` = infinity; all `visited`, `pred` = 0.
  - An operation in flight is aborted with no `done` and no partial write.
- **Scan order:** the scan reads the table as it stood at `start`. No other write can occur mid-scan.

## Test plan
- **Reset/clear:** apply reset, then READ_DIST idx 5. Expect `result`=0xFFFFFFFF, `done` at T+2, `done`=0 during reset.
- **Relax rules:**
  - SET_DIST idx 0 = 0; RELAX idx 3, d=10, pred 0 → 1.
  - RELAX idx 3, d=10 → 0.
  - RELAX idx 3, d=7, pred 2 → 1.
  - READ_PRED 3 → 2.
- **Extract tie and empty:**
  - dist[4]=5, dist[9]=5, all others infinity. EXTRACT → 4, with `done` at T+65; EXTRACT → 9; EXTRACT → 0xFFFFFFFF.
  - RELAX idx 4, d=1 → 0 (visited).
- **Out-of-range:** RELAX idx 64 → 0, no table change. SET_DIST idx 0x1_0040 is ignored.
- **Busy and clk_en:**
  - A `start` issued mid-EXTRACT is ignored.
  - Holding `clk_en` low for 10 cycles during SCAN delays `done` to T+75.
  - Asserting reset mid-SCAN gives no `done` and no visited bit set.

Source files
------------

// File: rtl/dijkstra_frontier_ci.sv
// Dijkstra working-set custom instruction: per-node distance/predecessor/visited tables
// with RELAX updates and a sequential minimum-scan EXTRACT_MIN.
module dijkstra_frontier_ci #(
  parameter int unsigned NODES  = 64,
  parameter int unsigned DIST_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [2:0]  n,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic        done,
  output logic [31:0] result
);

  localparam int unsigned IdxW = $clog2(NODES);
  localparam logic [DIST_W-1:0] Inf = '1;

  localparam logic [2:0] OpClear    = 3'd0;
  localparam logic [2:0] OpRelax    = 3'd1;
  localparam logic [2:0] OpExtract  = 3'd2;
  localparam logic [2:0] OpReadDist = 3'd3;
  localparam logic [2:0] OpReadPred = 3'd4;
  localparam logic [2:0] OpSetDist  = 3'd5;

  typedef enum logic [2:0] {StIdle, StRelax, StRead, StScan, StCommit} state_e;

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [15:0]         idx_q, idx_d;
  logic [15:0]         pin_q, pin_d;
  logic [DIST_W-1:0]   dval_q, dval_d;
  logic [DIST_W-1:0]   rd_dist_q, rd_dist_d;
  logic [15:0]         rd_pred_q, rd_pred_d;
  logic                rd_vis_q, rd_vis_d;
  logic [IdxW-1:0]     scan_q, scan_d;
  logic [IdxW-1:0]     min_idx_q, min_idx_d;
  logic [DIST_W-1:0]   min_val_q, min_val_d;
  logic                done_q, done_d;
  logic [31:0]         result_q, result_d;
  logic [DIST_W-1:0]   dist_q [NODES];
  logic [DIST_W-1:0]   dist_d [NODES];
  logic [15:0]         pred_q [NODES];
  logic [15:0]         pred_d [NODES];
  logic [NODES-1:0]    vis_q, vis_d;

  logic                in_range;
  logic [IdxW-1:0]     idx_lo;

  assign in_range = (32'(idx_q) < NODES);
  assign idx_lo   = idx_q[IdxW-1:0];

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    idx_d     = idx_q;
    pin_d     = pin_q;
    dval_d    = dval_q;
    rd_dist_d = rd_dist_q;
    rd_pred_d = rd_pred_q;
    rd_vis_d  = rd_vis_q;
    scan_d    = scan_q;
    min_idx_d = min_idx_q;
    min_val_d = min_val_q;
    done_d    = 1'b0;
    result_d  = result_q;
    dist_d    = dist_q;
    pred_d    = pred_q;
    vis_d     = vis_q;

    unique case (state_q)
      StIdle: begin
        // The done cycle is still StIdle; a start there is deliberately dropped.
        if (start && !done_q) begin
          op_d   = n;
          idx_d  = dataa[15:0];
          pin_d  = dataa[31:16];
          dval_d = datab[DIST_W-1:0];
          unique case (n)
            OpRelax, OpReadDist, OpReadPred: state_d = StRead;
            OpExtract: begin
              state_d   = StScan;
              scan_d    = '0;
              min_idx_d = '0;
              min_val_d = Inf;
            end
            default: state_d = StCommit;
          endcase
        end
      end

      StRead: begin
        rd_dist_d = dist_q[idx_lo];
        rd_pred_d = pred_q[idx_lo];
        rd_vis_d  = vis_q[idx_lo];
        state_d   = StRelax;
      end

      StRelax: begin
        done_d   = 1'b1;
        state_d  = StIdle;
        result_d = '0;
        unique case (op_q)
          OpRelax: begin
            if (in_range && !rd_vis_q && (dval_q < rd_dist_q)) begin
              dist_d[idx_lo] = dval_q;
              pred_d[idx_lo] = pin_q;
              result_d       = 32'd1;
            end
          end
          OpReadDist: result_d = in_range ? 32'(rd_dist_q) : '1;
          OpReadPred: result_d = in_range ? {16'b0, rd_pred_q} : '0;
          default:    result_d = '0;
        endcase
      end

      StScan: begin
        // Infinity never beats the Inf seed, so min_val_q != Inf means a candidate exists.
        if (!vis_q[scan_q] && (dist_q[scan_q] < min_val_q)) begin
          min_val_d = dist_q[scan_q];
          min_idx_d = scan_q;
        end
        if (scan_q == IdxW'(NODES - 1)) begin
          state_d = StCommit;
        end else begin
          scan_d = scan_q + 1'b1;
        end
      end

      StCommit: begin
        done_d   = 1'b1;
        state_d  = StIdle;
        result_d = '0;
        unique case (op_q)
          OpClear: begin
            for (int i = 0; i < NODES; i++) begin
              dist_d[i] = Inf;
              pred_d[i] = '0;
            end
            vis_d = '0;
          end
          OpSetDist: begin
            if (in_range) begin
              dist_d[idx_lo] = dval_q;
              vis_d[idx_lo]  = 1'b0;
            end
          end
          OpExtract: begin
            if (min_val_q != Inf) begin
              vis_d[min_idx_q] = 1'b1;
              result_d         = 32'(min_idx_q);
            end else begin
              result_d = '1;
            end
          end
          default: result_d = '0;
        endcase
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      op_q      <= '0;
      idx_q     <= '0;
      pin_q     <= '0;
      dval_q    <= '0;
      rd_dist_q <= '0;
      rd_pred_q <= '0;
      rd_vis_q  <= 1'b0;
      scan_q    <= '0;
      min_idx_q <= '0;
      min_val_q <= Inf;
      done_q    <= 1'b0;
      result_q  <= '0;
      dist_q    <= '{default: Inf};
      pred_q    <= '{default: '0};
      vis_q     <= '0;
    end else if (clk_en) begin
      state_q   <= state_d;
      op_q      <= op_d;
      idx_q     <= idx_d;
      pin_q     <= pin_d;
      dval_q    <= dval_d;
      rd_dist_q <= rd_dist_d;
      rd_pred_q <= rd_pred_d;
      rd_vis_q  <= rd_vis_d;
      scan_q    <= scan_d;
      min_idx_q <= min_idx_d;
      min_val_q <= min_val_d;
      done_q    <= done_d;
      result_q  <= result_d;
      dist_q    <= dist_d;
      pred_q    <= pred_d;
      vis_q     <= vis_d;
    end
  end

  // A done pulse caught by a clk_en drop is frozen and shows once clk_en returns.
  assign done   = done_q & clk_en;
  assign result = result_q;

endmodule

// File: tb/tb_dijkstra_frontier_ci.sv
// Scoreboard bench for dijkstra_frontier_ci: stimulus pushes expected result and done cycle,
// an independent monitor pops and checks on every done.
module tb_dijkstra_frontier_ci;

  logic        clk;
  logic        reset;
  logic        clk_en;
  logic        start;
  logic [2:0]  n;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic        done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  dijkstra_frontier_ci #(.NODES(64), .DIST_W(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .start  (start),
    .n      (n),
    .dataa  (dataa),
    .datab  (datab),
    .done   (done),
    .result (result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // Monitor: all comparisons live here.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        total = total + 1;
        if (done !== 1'b0) begin
          bad = bad + 1;
          $display("FAIL done_in_reset: got done=%b need 0 at cyc %0d", done, cyc);
        end
      end else if (done === 1'b1) begin
        if (sb.size() == 0) begin
          total = total + 1;
          bad   = bad + 1;
          $display("FAIL unexpected_done: result=%h at cyc %0d", result, cyc);
        end else begin
          e     = sb.pop_front();
          total = total + 2;
          if (result !== e.res) begin
            bad = bad + 1;
            $display("FAIL %s: result got %h need %h", e.name, result, e.res);
          end
          if (cyc != e.cyc) begin
            bad = bad + 1;
            $display("FAIL %s_timing: done at cyc %0d need %0d", e.name, cyc, e.cyc);
          end
        end
      end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
        e     = sb.pop_front();
        total = total + 1;
        bad   = bad + 1;
        $display("FAIL %s_timeout: no done by cyc %0d need done at %0d", e.name, cyc, e.cyc);
      end
    end
  end

  task automatic issue_hold(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_res, input int lat, input int hold,
                            input string name);
    exp_t e;
    @(posedge clk);
    #1;
    start = 1'b1;
    n     = op;
    dataa = a;
    datab = b;
    e.res  = exp_res;
    e.cyc  = cyc + 1 + lat;
    e.name = name;
    sb.push_back(e);
    repeat (hold) @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input int lat, input string name);
    issue_hold(op, a, b, exp_res, lat, 1, name);
  endtask

  // Start pulse with no expected response (must be ignored or aborted).
  task automatic pulse(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    start = 1'b1;
    n     = op;
    dataa = a;
    datab = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (sb.size() != 0 && k < 300) begin
      @(posedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      $display("FAIL wait_idle: scoreboard stuck with %0d entries", sb.size());
      $fatal(1, "bench stalled");
    end
    @(posedge clk);
  endtask

  task automatic op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] exp_res, input int lat, input string name);
    issue(o, a, b, exp_res, lat, name);
    wait_idle();
  endtask

  localparam logic [31:0] AllOnes = 32'hFFFF_FFFF;

  initial begin
    reset  = 1'b0;
    clk_en = 1'b1;
    start  = 1'b0;
    n      = '0;
    dataa  = '0;
    datab  = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // reset state
    op(3'd3, 32'd5, 32'd0, AllOnes, 2, "rst_dist5");
    op(3'd4, 32'd5, 32'd0, 32'd0,   2, "rst_pred5");

    // relax rules
    op(3'd5, 32'd0, 32'd0, 32'd0, 1, "set_src");
    op(3'd1, {16'd0, 16'd3}, 32'd10, 32'd1, 2, "relax3_10");
    op(3'd1, {16'd0, 16'd3}, 32'd10, 32'd0, 2, "relax3_eq");
    op(3'd1, {16'd2, 16'd3}, 32'd7,  32'd1, 2, "relax3_7");
    op(3'd4, 32'd3, 32'd0, 32'd2, 2, "pred3");
    op(3'd3, 32'd3, 32'd0, 32'd7, 2, "dist3");
    op(3'd3, 32'd0, 32'd0, 32'd0, 2, "dist0");

    // clear
    op(3'd0, 32'd0, 32'd0, 32'd0, 1, "clear");
    op(3'd3, 32'd3, 32'd0, AllOnes, 2, "dist3_clr");
    op(3'd4, 32'd3, 32'd0, 32'd0,   2, "pred3_clr");

    // extract tie and empty
    op(3'd5, 32'd4, 32'd5, 32'd0, 1, "set4");
    op(3'd5, 32'd9, 32'd5, 32'd0, 1, "set9");
    op(3'd2, 32'd0, 32'd0, 32'd4,   65, "ext_tie");
    op(3'd2, 32'd0, 32'd0, 32'd9,   65, "ext_second");
    op(3'd2, 32'd0, 32'd0, AllOnes, 65, "ext_empty");
    op(3'd1, {16'd0, 16'd4}, 32'd1, 32'd0, 2, "relax_visited");
    op(3'd3, 32'd4, 32'd0, 32'd5, 2, "dist4_kept");

    // out of range
    op(3'd1, 32'd64, 32'd0, 32'd0, 2, "relax_oor");
    op(3'd5, 32'h0001_0040, 32'd3, 32'd0, 1, "set_oor");
    op(3'd3, 32'd0, 32'd0, AllOnes, 2, "dist0_untouched");
    op(3'd3, 32'd64, 32'd0, AllOnes, 2, "read_oor");
    op(3'd4, 32'd64, 32'd0, 32'd0,   2, "pred_oor");
    op(3'd6, 32'd1, 32'd1, 32'd0, 1, "nop6");
    op(3'd7, 32'd1, 32'd1, 32'd0, 1, "nop7");

    // busy: a CLEAR issued mid-scan must not be taken
    op(3'd0, 32'd0, 32'd0, 32'd0, 1, "clear2");
    op(3'd5, 32'd20, 32'd8, 32'd0, 1, "set20");
    op(3'd5, 32'd30, 32'd3, 32'd0, 1, "set30");
    issue(3'd2, 32'd0, 32'd0, 32'd30, 65, "ext_busy");
    repeat (10) @(posedge clk);
    pulse(3'd0, 32'd0, 32'd0);
    wait_idle();

    // clk_en low for 10 edges mid-scan
    issue(3'd2, 32'd0, 32'd0, 32'd20, 75, "ext_clken");
    repeat (5) @(posedge clk);
    #1 clk_en = 1'b0;
    repeat (10) @(posedge clk);
    #1 clk_en = 1'b1;
    wait_idle();
    op(3'd2, 32'd0, 32'd0, AllOnes, 65, "ext_empty2");

    // start held into the done cycle is accepted once only
    issue_hold(3'd5, 32'd50, 32'd1, 32'd0, 1, 3, "set_hold");
    wait_idle();
    op(3'd3, 32'd50, 32'd0, 32'd1, 2, "dist50");

    // reset mid-scan: no done, tables back to reset state
    op(3'd5, 32'd11, 32'd2, 32'd0, 1, "set11");
    pulse(3'd2, 32'd0, 32'd0);
    repeat (20) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (80) @(posedge clk);
    op(3'd3, 32'd11, 32'd0, AllOnes, 2, "dist11_rst");
    op(3'd5, 32'd11, 32'd2, 32'd0, 1, "set11_again");
    op(3'd2, 32'd0, 32'd0, 32'd11, 65, "ext_after_rst");

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
